regfile_multiport: RTL and testbench

Parametrised register file: DEPTH registers of WIDTH bits, one synchronous write port, NREAD independent read ports. Each read port is a DEPTH:1 selection tree over the storage array. The outputs are optionally registered, with write-first bypass and a per-port valid flag. It is the next-generation storage block of the register-file datapath and feeds the operand-fetch stage in place of fixed 32:1 read muxes.

---
 rtl/regfile_multiport.sv | 93 +++++++++
 tb/tb_regfile_multiport.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_multiport.sv
// Multiport register file: DEPTH x WIDTH flops, one write port, NREAD independent read ports, hardwired zero entry.
// Latency: 1 cycle read with write-first bypass when REG_OUT=1, combinational read with no bypass when REG_OUT=0.
// Backpressure: none; one write and NREAD reads are accepted every cycle.
module regfile_multiport #(
    parameter int WIDTH    = 64,
    parameter int DEPTH    = 32,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = DEPTH - 1,
    parameter int REG_OUT  = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic [NREAD-1:0]           rd_en,
    input  logic [NREAD*$clog2(DEPTH)-1:0] rd_addr,
    output logic [NREAD*WIDTH-1:0]     rd_data,
    output logic [NREAD-1:0]           rd_valid
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    // The zero entry never loads, so its flop stays at its reset value of 0.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            mem_d[k] = mem_q[k];
            if (wr_en && (wr_addr == AW'(k)) && (k != ZERO_REG)) begin
                mem_d[k] = wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= mem_d[k];
            end
        end
    end

    for (genvar p = 0; p < NREAD; p++) begin : g_rd
        logic [AW-1:0]    addr;
        logic             hit_zero;
        logic [WIDTH-1:0] sel;

        assign addr     = rd_addr[p*AW +: AW];
        assign hit_zero = (addr == AW'(ZERO_REG));
        assign sel      = hit_zero ? '0 : mem_q[addr];

        if (REG_OUT != 0) begin : g_reg
            logic [WIDTH-1:0] data_q;
            logic [WIDTH-1:0] data_d;
            logic             vld_q;
            logic             vld_d;
            logic             bypass;

            // Write-first: a same-edge write to the requested entry wins over the stored value.
            always_comb begin
                bypass = wr_en && (wr_addr == addr) && !hit_zero;
                data_d = data_q;
                vld_d  = rd_en[p];
                if (rd_en[p]) begin
                    data_d = bypass ? wr_data : sel;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    data_q <= '0;
                    vld_q  <= 1'b0;
                end else begin
                    data_q <= data_d;
                    vld_q  <= vld_d;
                end
            end

            assign rd_data[p*WIDTH +: WIDTH] = data_q;
            assign rd_valid[p]               = vld_q;
        end else begin : g_comb
            assign rd_data[p*WIDTH +: WIDTH] = reset ? '0 : sel;
            assign rd_valid[p]               = rd_en[p] & ~reset;
        end
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// Scoreboard bench: stimulus pushes expected read results tagged with the cycle they are due; negedge monitors pop and compare.
module tb_regfile_multiport;

    typedef struct {
        int          due;
        int          phase;
        logic        vld;
        logic        chkd;
        logic [63:0] dat;
    } item_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int compared   = 0;
    int mismatched = 0;
    int phase      = 0;

    // Shared stimulus for the registered (A) and combinational (B) instances.
    logic         rst = 1'b1;
    logic         we  = 1'b0;
    logic [4:0]   wa  = '0;
    logic [63:0]  wd  = '0;
    logic [1:0]   re  = '0;
    logic [9:0]   ra  = '0;
    logic [127:0] a_rd;
    logic [1:0]   a_rv;
    logic [127:0] b_rd;
    logic [1:0]   b_rv;

    // Four-port, 16-entry registered instance (C).
    logic         c_rst = 1'b1;
    logic         c_we  = 1'b0;
    logic [3:0]   c_wa  = '0;
    logic [63:0]  c_wd  = '0;
    logic [3:0]   c_re  = '0;
    logic [15:0]  c_ra  = '0;
    logic [255:0] c_rd;
    logic [3:0]   c_rv;

    regfile_multiport #(.WIDTH(64), .DEPTH(32), .NREAD(2), .ZERO_REG(31), .REG_OUT(1)) u_a (
        .clk(clk), .reset(rst), .wr_en(we), .wr_addr(wa), .wr_data(wd),
        .rd_en(re), .rd_addr(ra), .rd_data(a_rd), .rd_valid(a_rv)
    );

    regfile_multiport #(.WIDTH(64), .DEPTH(32), .NREAD(2), .ZERO_REG(31), .REG_OUT(0)) u_b (
        .clk(clk), .reset(rst), .wr_en(we), .wr_addr(wa), .wr_data(wd),
        .rd_en(re), .rd_addr(ra), .rd_data(b_rd), .rd_valid(b_rv)
    );

    regfile_multiport #(.WIDTH(64), .DEPTH(16), .NREAD(4), .ZERO_REG(15), .REG_OUT(1)) u_c (
        .clk(clk), .reset(c_rst), .wr_en(c_we), .wr_addr(c_wa), .wr_data(c_wd),
        .rd_en(c_re), .rd_addr(c_ra), .rd_data(c_rd), .rd_valid(c_rv)
    );

    item_t qa[2][$];
    item_t qb[2][$];
    item_t qc[4][$];

    function automatic item_t mk(input int lat, input logic v, input logic c, input logic [63:0] d);
        item_t it;
        it.due   = cyc + lat;
        it.phase = phase;
        it.vld   = v;
        it.chkd  = c;
        it.dat   = d;
        return it;
    endfunction

    task automatic exp_a(input int p, input logic v, input logic c, input logic [63:0] d);
        qa[p].push_back(mk(1, v, c, d));
    endtask

    task automatic exp_b(input int p, input logic v, input logic c, input logic [63:0] d);
        qb[p].push_back(mk(0, v, c, d));
    endtask

    task automatic exp_c(input int p, input logic v, input logic c, input logic [63:0] d);
        qc[p].push_back(mk(1, v, c, d));
    endtask

    task automatic check(input string nm, input int p, input item_t it, input logic v, input logic [63:0] d);
        compared++;
        if (it.due != cyc || v !== it.vld || (it.chkd && d !== it.dat)) begin
            mismatched++;
            $display("FAIL %s port%0d phase%0d cyc%0d(due %0d): got vld=%b dat=%h, expected vld=%b dat=%h%s",
                     nm, p, it.phase, cyc, it.due, v, d, it.vld, it.dat, it.chkd ? "" : " (data not checked)");
        end
    endtask

    always @(negedge clk) begin
        item_t it;
        for (int p = 0; p < 2; p++) begin
            while (qa[p].size() > 0 && qa[p][0].due <= cyc) begin
                it = qa[p].pop_front();
                check("regout1", p, it, a_rv[p], a_rd[p*64 +: 64]);
            end
            while (qb[p].size() > 0 && qb[p][0].due <= cyc) begin
                it = qb[p].pop_front();
                check("regout0", p, it, b_rv[p], b_rd[p*64 +: 64]);
            end
        end
        for (int p = 0; p < 4; p++) begin
            while (qc[p].size() > 0 && qc[p][0].due <= cyc) begin
                it = qc[p].pop_front();
                check("nread4", p, it, c_rv[p], c_rd[p*64 +: 64]);
            end
        end
    end

    task automatic drv(input logic r, input logic w, input logic [4:0] wa_v, input logic [63:0] wd_v,
                       input logic [1:0] re_v, input logic [4:0] a0, input logic [4:0] a1);
        @(posedge clk);
        #1;
        rst = r; we = w; wa = wa_v; wd = wd_v; re = re_v; ra = {a1, a0};
    endtask

    task automatic drvc(input logic r, input logic w, input logic [3:0] wa_v, input logic [63:0] wd_v,
                        input logic [3:0] re_v, input logic [15:0] ra_v);
        @(posedge clk);
        #1;
        c_rst = r; c_we = w; c_wa = wa_v; c_wd = wd_v; c_re = re_v; c_ra = ra_v;
    endtask

    function automatic logic [63:0] val(input int a);
        return (a == 31) ? 64'h0 : 64'hDEADBEEF_00000000 + 64'(a);
    endfunction

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        // Reset for two cycles; the combinational instance must force zeros even while reading.
        phase = 1;
        for (int i = 0; i < 2; i++) begin
            drv(1, 0, 0, 0, 2'b11, 5'd3, 5'd9);
            exp_b(0, 0, 1, 64'h0);
            exp_b(1, 0, 1, 64'h0);
        end
        drv(0, 0, 0, 0, 2'b00, 0, 0);
        qa[0].push_back(mk(0, 0, 1, 64'h0));
        qa[1].push_back(mk(0, 0, 1, 64'h0));

        phase = 2;
        for (int k = 0; k < 32; k++) begin
            drv(0, 0, 0, 0, 2'b11, 5'(k), 5'(31 - k));
            for (int p = 0; p < 2; p++) begin
                exp_a(p, 1, 1, 64'h0);
                exp_b(p, 1, 1, 64'h0);
            end
        end

        phase = 3;
        for (int k = 0; k < 31; k++) begin
            drv(0, 1, 5'(k), 64'hDEADBEEF_00000000 + 64'(k), 2'b00, 0, 0);
        end
        for (int k = 0; k < 32; k++) begin
            drv(0, 0, 0, 0, 2'b11, 5'(k), 5'(31 - k));
            exp_a(0, 1, 1, val(k));
            exp_a(1, 1, 1, val(31 - k));
            exp_b(0, 1, 1, val(k));
            exp_b(1, 1, 1, val(31 - k));
        end

        phase = 4;
        drv(0, 1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 0, 0);
        drv(0, 0, 0, 0, 2'b11, 5'd31, 5'd30);
        exp_a(0, 1, 1, 64'h0); exp_a(1, 1, 1, val(30));
        exp_b(0, 1, 1, 64'h0); exp_b(1, 1, 1, val(30));
        drv(0, 0, 0, 0, 2'b11, 5'd31, 5'd0);
        exp_a(0, 1, 1, 64'h0); exp_a(1, 1, 1, val(0));
        exp_b(0, 1, 1, 64'h0); exp_b(1, 1, 1, val(0));

        phase = 5;
        drv(0, 1, 5'd5, 64'h11, 2'b00, 0, 0);
        drv(0, 1, 5'd5, 64'h22, 2'b11, 5'd5, 5'd5);
        exp_a(0, 1, 1, 64'h22); exp_a(1, 1, 1, 64'h22);
        exp_b(0, 1, 1, 64'h11); exp_b(1, 1, 1, 64'h11);
        drv(0, 0, 0, 0, 2'b11, 5'd5, 5'd5);
        exp_a(0, 1, 1, 64'h22); exp_a(1, 1, 1, 64'h22);
        exp_b(0, 1, 1, 64'h22); exp_b(1, 1, 1, 64'h22);

        phase = 6;
        drv(0, 1, 5'd3, 64'h33, 2'b00, 0, 0);
        drv(0, 0, 0, 0, 2'b01, 5'd3, 5'd0);
        exp_a(0, 1, 1, 64'h33); exp_a(1, 0, 0, 64'h0);
        exp_b(0, 1, 1, 64'h33);
        drv(0, 0, 0, 0, 2'b00, 5'd4, 5'd0);
        exp_a(0, 0, 1, 64'h33); exp_b(0, 0, 1, val(4));
        drv(0, 0, 0, 0, 2'b00, 5'd3, 5'd0);
        exp_a(0, 0, 1, 64'h33); exp_b(0, 0, 1, 64'h33);
        drv(0, 0, 0, 0, 2'b00, 5'd4, 5'd0);
        exp_a(0, 0, 1, 64'h33); exp_b(0, 0, 1, val(4));

        phase = 7;
        drv(1, 1, 5'd7, 64'h77, 2'b11, 5'd7, 5'd7);
        exp_a(0, 0, 1, 64'h0); exp_a(1, 0, 1, 64'h0);
        exp_b(0, 0, 1, 64'h0); exp_b(1, 0, 1, 64'h0);
        drv(0, 0, 0, 0, 2'b11, 5'd7, 5'd3);
        exp_a(0, 1, 1, 64'h0); exp_a(1, 1, 1, 64'h0);
        exp_b(0, 1, 1, 64'h0); exp_b(1, 1, 1, 64'h0);
        drv(0, 0, 0, 0, 2'b00, 0, 0);

        phase = 8;
        drvc(1, 0, 0, 0, 4'h0, 16'h0);
        drvc(1, 0, 0, 0, 4'h0, 16'h0);
        drvc(0, 1, 4'd7, 64'h77, 4'h0, 16'h0);
        drvc(0, 1, 4'd15, 64'hFFFF_FFFF_FFFF_FFFF, 4'h0, 16'h0);
        drvc(0, 0, 0, 0, 4'hF, {4'd15, 4'd7, 4'd15, 4'd7});
        exp_c(0, 1, 1, 64'h77); exp_c(1, 1, 1, 64'h0);
        exp_c(2, 1, 1, 64'h77); exp_c(3, 1, 1, 64'h0);
        drvc(1, 1, 4'd7, 64'h88, 4'hF, {4'd7, 4'd7, 4'd7, 4'd7});
        for (int p = 0; p < 4; p++) exp_c(p, 0, 1, 64'h0);
        drvc(0, 0, 0, 0, 4'hF, {4'd7, 4'd7, 4'd7, 4'd7});
        for (int p = 0; p < 4; p++) exp_c(p, 1, 1, 64'h0);
        drvc(0, 0, 0, 0, 4'h0, 16'h0);

        repeat (4) @(posedge clk);
        @(negedge clk);
        #1;
        for (int p = 0; p < 4; p++) begin
            if (p < 2 && (qa[p].size() != 0 || qb[p].size() != 0)) begin
                compared++;
                mismatched++;
                $display("FAIL drain port%0d: got %0d/%0d pending items, expected 0", p, qa[p].size(), qb[p].size());
            end
            if (qc[p].size() != 0) begin
                compared++;
                mismatched++;
                $display("FAIL drain nread4 port%0d: got %0d pending items, expected 0", p, qc[p].size());
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
